// File: rtl/bcd_time_counter.sv
// MM:SS BCD time counter with seconds prescaler, up/down counting, countdown expiry,
// validated digit preset and lap capture (lap capture built only when TIME_LAP_EN is defined).
module bcd_time_counter #(
    parameter int TICK_DIV     = 100000000,
    parameter int MIN_TENS_MAX = 9,
    parameter int PRE_W        = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        dir,
    input  logic        set_en,
    input  logic [1:0]  set_sel,
    input  logic [3:0]  set_val,
    input  logic        lap,
    output logic [15:0] time_bcd,
    output logic [15:0] lap_bcd,
    output logic        lap_valid,
    output logic        tick,
    output logic        done,
    output logic        expired
);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [3:0]       MIN_L_MAX = 4'(MIN_TENS_MAX);

    logic [3:0]       sec_r_q, sec_l_q, min_r_q, min_l_q;
    logic [3:0]       sec_r_d, sec_l_d, min_r_d, min_l_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             expired_q, expired_d;

    logic [3:0] up_sr, up_sl, up_mr, up_ml;
    logic [3:0] dn_sr, dn_sl, dn_mr, dn_ml;
    logic       up_c0, up_c1, up_c2;
    logic       dn_b0, dn_b1, dn_b2;
    logic       set_ok, time_zero, dn_zero;
    logic       pre_en, pre_wrap, step_ok;

    assign time_bcd = {min_l_q, min_r_q, sec_l_q, sec_r_q};
    assign time_zero = (time_bcd == 16'h0000);

    // Ripple carry/borrow through the four digits, one candidate result per direction.
    always_comb begin
        up_c0 = (sec_r_q == 4'd9);
        up_sr = up_c0 ? 4'd0 : sec_r_q + 4'd1;
        up_c1 = up_c0 && (sec_l_q == 4'd5);
        up_sl = up_c0 ? (up_c1 ? 4'd0 : sec_l_q + 4'd1) : sec_l_q;
        up_c2 = up_c1 && (min_r_q == 4'd9);
        up_mr = up_c1 ? (up_c2 ? 4'd0 : min_r_q + 4'd1) : min_r_q;
        up_ml = up_c2 ? ((min_l_q >= MIN_L_MAX) ? 4'd0 : min_l_q + 4'd1) : min_l_q;

        dn_b0 = (sec_r_q == 4'd0);
        dn_sr = dn_b0 ? 4'd9 : sec_r_q - 4'd1;
        dn_b1 = dn_b0 && (sec_l_q == 4'd0);
        dn_sl = dn_b0 ? (dn_b1 ? 4'd5 : sec_l_q - 4'd1) : sec_l_q;
        dn_b2 = dn_b1 && (min_r_q == 4'd0);
        dn_mr = dn_b1 ? (dn_b2 ? 4'd9 : min_r_q - 4'd1) : min_r_q;
        dn_ml = dn_b2 ? ((min_l_q == 4'd0) ? 4'd0 : min_l_q - 4'd1) : min_l_q;

        dn_zero = ({dn_ml, dn_mr, dn_sl, dn_sr} == 16'h0000);
    end

    always_comb begin
        set_ok = 1'b0;
        if (set_en) begin
            case (set_sel)
                2'd0:    set_ok = (set_val <= 4'd9);
                2'd1:    set_ok = (set_val <= 4'd5);
                2'd2:    set_ok = (set_val <= 4'd9);
                default: set_ok = (set_val <= MIN_L_MAX);
            endcase
        end
    end

    // Once a countdown has expired the prescaler stays frozen until dir returns to up.
    assign pre_en   = run && !(dir && expired_q);
    assign pre_wrap = pre_en && (pre_q == PRE_LAST);
    assign step_ok  = pre_wrap && !(dir && time_zero);

    always_comb begin
        sec_r_d   = sec_r_q;
        sec_l_d   = sec_l_q;
        min_r_d   = min_r_q;
        min_l_d   = min_l_q;
        pre_d     = pre_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        expired_d = expired_q && dir;
        if (set_ok) begin
            pre_d     = '0;
            expired_d = 1'b0;
            case (set_sel)
                2'd0:    sec_r_d = set_val;
                2'd1:    sec_l_d = set_val;
                2'd2:    min_r_d = set_val;
                default: min_l_d = set_val;
            endcase
        end else begin
            if (pre_en) begin
                pre_d = pre_wrap ? '0 : pre_q + 1'b1;
            end
            if (step_ok) begin
                tick_d = 1'b1;
                if (dir) begin
                    {min_l_d, min_r_d, sec_l_d, sec_r_d} = {dn_ml, dn_mr, dn_sl, dn_sr};
                    if (dn_zero) begin
                        done_d    = 1'b1;
                        expired_d = 1'b1;
                    end
                end else begin
                    {min_l_d, min_r_d, sec_l_d, sec_r_d} = {up_ml, up_mr, up_sl, up_sr};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_r_q   <= 4'd0;
            sec_l_q   <= 4'd0;
            min_r_q   <= 4'd0;
            min_l_q   <= 4'd0;
            pre_q     <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            sec_r_q   <= sec_r_d;
            sec_l_q   <= sec_l_d;
            min_r_q   <= min_r_d;
            min_l_q   <= min_l_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    assign tick    = tick_q;
    assign done    = done_q;
    assign expired = expired_q;

`ifdef TIME_LAP_EN
    logic [15:0] lap_bcd_q, lap_bcd_d;
    logic        lap_valid_q, lap_valid_d;

    // An accepted preset outranks lap; a lap on a step cycle captures the pre-step time.
    always_comb begin
        lap_bcd_d   = lap_bcd_q;
        lap_valid_d = lap_valid_q;
        if (lap && !set_ok) begin
            lap_bcd_d   = time_bcd;
            lap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_bcd_q   <= 16'h0000;
            lap_valid_q <= 1'b0;
        end else begin
            lap_bcd_q   <= lap_bcd_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign lap_bcd   = lap_bcd_q;
    assign lap_valid = lap_valid_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_bcd    = 16'h0000;
    assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed table bench for bcd_time_counter (TICK_DIV=4); expected outputs are queued per row
// and compared after the row's last clock edge, followed by pulse-width sequences.
`timescale 1ns/1ps
module tb_bcd_time_counter;

`ifdef TIME_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    typedef struct {
        logic        rst, run, dir, set_en;
        logic [1:0]  sel;
        logic [3:0]  val;
        logic        lap;
        int          n;
        logic [15:0] t;
        logic        tk, dn, ex, lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, run = 1'b0, dir = 1'b0, set_en = 1'b0, lap = 1'b0;
    logic [1:0]  set_sel = 2'd0;
    logic [3:0]  set_val = 4'd0;
    logic [15:0] time_bcd, lap_bcd;
    logic        lap_valid, tick, done, expired;

    int n_cmp = 0;
    int n_bad = 0;
    logic [35:0] exp_q[$];
    vec_t        vecs[$];

    bcd_time_counter #(.TICK_DIV(4), .MIN_TENS_MAX(9), .PRE_W(3)) dut (
        .clk(clk), .rst(rst), .run(run), .dir(dir), .set_en(set_en),
        .set_sel(set_sel), .set_val(set_val), .lap(lap),
        .time_bcd(time_bcd), .lap_bcd(lap_bcd), .lap_valid(lap_valid),
        .tick(tick), .done(done), .expired(expired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic r, ru, d, s, input logic [1:0] sl,
                                input logic [3:0] vl, input logic lp, input int n,
                                input logic [15:0] t, input logic tk, dn, ex, lo);
        vec_t v;
        v.rst = r; v.run = ru; v.dir = d; v.set_en = s; v.sel = sl; v.val = vl; v.lap = lp;
        v.n = n; v.t = t; v.tk = tk; v.dn = dn; v.ex = ex; v.lo = lo;
        return v;
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got {time,tick,done,exp,lap,lapv}=%h required %h", name, act, req);
        end else begin
            $display("ok   %s: time=%h tick=%b done=%b exp=%b lap=%h lapv=%b",
                     name, act[35:20], act[19], act[18], act[17], act[16:1], act[0]);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        logic [35:0] e;
        logic [15:0] le;
        rst = v.rst; run = v.run; dir = v.dir; set_en = v.set_en;
        set_sel = v.sel; set_val = v.val; lap = v.lap;
        le = (v.lo && LAP_ON) ? 16'h0003 : 16'h0000;
        exp_q.push_back({v.t, v.tk, v.dn, v.ex, le, v.lo && LAP_ON});
        repeat (v.n) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("row%0d", idx), {time_bcd, tick, done, expired, lap_bcd, lap_valid}, e);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    initial begin
        int ticks, dones, dbl;
        logic prev;
        //              rst run dir set sel val  lap n   time     tk dn ex lo
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'd0, 0, 2, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 3, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 1, 16'h0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 3, 16'h0001, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 1, 16'h0002, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 4'd9, 0, 1, 16'h0902, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 4'd5, 0, 1, 16'h0952, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'd9, 0, 1, 16'h0959, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 3, 16'h0959, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 1, 16'h1000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 4'd9, 0, 1, 16'h9000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 4'd9, 0, 1, 16'h9900, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 4'd5, 0, 1, 16'h9950, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'd9, 0, 1, 16'h9959, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 4, 16'h0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'd2, 0, 1, 16'h0002, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 4, 16'h0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 4, 16'h0000, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 1, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 40, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 1, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 3, 16'h0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 2, 16'h0001, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 4'd7, 0, 1, 16'h0001, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 1, 16'h0002, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 2, 16'h0002, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 4'd5, 0, 1, 16'h0052, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 3, 16'h0052, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 1, 16'h0053, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3, 4'd5, 0, 1, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'd3, 0, 1, 16'h0003, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 3, 16'h0003, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 1, 1, 16'h0004, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 2, 16'h0004, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 0, 10, 16'h0004, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 1, 16'h0004, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 1, 16'h0005, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 2, 16'h0005, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 4'd0, 0, 1, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 3, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 1, 16'h0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 4'd1, 0, 1, 16'h1001, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'd0, 0, 1, 16'h1000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 4, 16'h0959, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 3, 4'd0, 0, 1, 16'h0959, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 2, 4'd0, 0, 1, 16'h0059, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'd0, 0, 1, 16'h0009, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'd0, 0, 1, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 8, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 4'hA, 0, 1, 16'h0000, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Up-count tick cadence and pulse width.
        rst = 1'b1; run = 1'b0; dir = 1'b0; set_en = 1'b0; lap = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b1;
        ticks = 0; dbl = 0; prev = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (tick) ticks++;
            if (tick && prev) dbl++;
            prev = tick;
        end
        check_int("seq_up_ticks", ticks, 3);
        check_int("seq_up_tick_width", dbl, 0);
        check_int("seq_up_time", int'(time_bcd), 16'h0003);

        // Countdown from 00:01: exactly one done pulse, then frozen and expired.
        run = 1'b0; set_en = 1'b1; set_sel = 2'd0; set_val = 4'd1;
        @(posedge clk); #1;
        set_en = 1'b0; run = 1'b1; dir = 1'b1;
        ticks = 0; dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (tick) ticks++;
            if (done) dones++;
        end
        check_int("seq_dn_done_pulses", dones, 1);
        check_int("seq_dn_ticks", ticks, 1);
        check_int("seq_dn_expired", int'(expired), 1);
        check_int("seq_dn_time", int'(time_bcd), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
